serial_rx_input_shifter_reg: RTL and testbench

Receive-side input shift register of the serial port (8051-style UART) in the 8-bit automotive microcontroller. It assembles an LSB-first serial frame, one bit per shift strobe from the receive control FSM, and flags frame completion. On command it transfers the byte to the receive SBUF and the ninth bit or stop bit to SCON.RB8. Bit timing, sampling and majority voting belong to the receive controller, not to this block.

---
 rtl/serial_rx_input_shifter_reg.sv | 145 ++++++++++++++
 tb/tb_serial_rx_input_shifter_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_input_shifter_reg.sv
// ---------------------------------------------------------------------------
// serial_rx_input_shifter_reg
//
// Receive-side input shift register of the 8051-style serial port. It
// assembles an LSB-first frame one bit per shift strobe. The first strobe
// after a start pulse is the start bit and is not stored. It flags frame
// completion. On a load pulse it transfers the byte to SBUF and the ninth
// bit or stop bit to RB8.
//
// Ports:
//   serial_clock_i                 system clock, rising edge
//   serial_reset_i_b               asynchronous active-low reset
//   serial_start_input_shift_reg_i arm a new reception (1-cycle pulse)
//   serial_shift_input_shift_reg_i shift in serial_data_i (1-cycle strobe)
//   serial_data_i                  sampled RXD bit
//   serial_receive_i               reception window; shifts ignored when low
//   serial_scon7_sm0_i             0: 8 data bits, 1: 9 data bits
//   serial_load_sbuf_i             transfer assembled frame to SBUF / RB8
//   serial_sbuf_rx_o               receive SBUF
//   serial_end_bit_o               last expected bit has been shifted in
//   serial_scon2_rb8_o             RB8 value
//
// Optional feature macro: SERIAL_RX_START_CHECK_EN
//   When defined, a start bit sampled as 1 is treated as a false start. The
//   block then ignores shifts until the next start pulse.
// ---------------------------------------------------------------------------
module serial_rx_input_shifter_reg (
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_start_input_shift_reg_i,
  input  logic       serial_shift_input_shift_reg_i,
  input  logic       serial_data_i,
  input  logic       serial_receive_i,
  input  logic       serial_scon7_sm0_i,
  input  logic       serial_load_sbuf_i,
  output logic [7:0] serial_sbuf_rx_o,
  output logic       serial_end_bit_o,
  output logic       serial_scon2_rb8_o
);

  logic [8:0] data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  logic       end_q, end_d;
  logic [7:0] sbuf_q, sbuf_d;
  logic       rb8_q, rb8_d;
  logic [3:0] frame_len;
  logic       shift_ok;

  // Start bit plus 8 or 9 data bits.
  assign frame_len = serial_scon7_sm0_i ? 4'd10 : 4'd9;

`ifdef SERIAL_RX_START_CHECK_EN
  logic idle_q, idle_d;
  // Once the count reaches the frame length, the comparison also blocks
  // any shifts that arrive after the end of the frame.
  assign shift_ok = serial_shift_input_shift_reg_i & serial_receive_i &
                    (cnt_q < frame_len) & ~idle_q;
`else
  assign shift_ok = serial_shift_input_shift_reg_i & serial_receive_i &
                    (cnt_q < frame_len);
`endif

  // Frame assembly: the start pulse takes priority over a shift.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    end_d  = end_q;
`ifdef SERIAL_RX_START_CHECK_EN
    idle_d = idle_q;
`endif
    if (serial_start_input_shift_reg_i) begin
      data_d = 9'h1FF;
      cnt_d  = 4'd0;
      end_d  = 1'b0;
`ifdef SERIAL_RX_START_CHECK_EN
      idle_d = 1'b0;
`endif
    end else if (shift_ok) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q != 4'd0) begin
        data_d = {serial_data_i, data_q[8:1]};
      end
`ifdef SERIAL_RX_START_CHECK_EN
      if ((cnt_q == 4'd0) && serial_data_i) begin
        // False start bit: park in idle with the count still at 0.
        idle_d = 1'b1;
        cnt_d  = 4'd0;
      end else if (cnt_q + 4'd1 == frame_len) begin
        end_d = 1'b1;
      end
`else
      if (cnt_q + 4'd1 == frame_len) begin
        end_d = 1'b1;
      end
`endif
    end
  end

  // SBUF/RB8 transfer samples the pre-shift contents.
  always_comb begin
    sbuf_d = sbuf_q;
    rb8_d  = rb8_q;
    if (serial_load_sbuf_i) begin
      if (serial_scon7_sm0_i) begin
        sbuf_d = data_q[7:0];
        rb8_d  = data_q[8];
      end else begin
        // Modes 0/1: RB8 takes the stop bit that is currently on the line.
        sbuf_d = data_q[8:1];
        rb8_d  = serial_data_i;
      end
    end
  end

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      data_q <= 9'h1FF;
      cnt_q  <= 4'd0;
      end_q  <= 1'b0;
      sbuf_q <= 8'h00;
      rb8_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      end_q  <= end_d;
      sbuf_q <= sbuf_d;
      rb8_q  <= rb8_d;
    end
  end

`ifdef SERIAL_RX_START_CHECK_EN
  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      idle_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign serial_sbuf_rx_o   = sbuf_q;
  assign serial_end_bit_o   = end_q;
  assign serial_scon2_rb8_o = rb8_q;

endmodule

// File: tb/tb_serial_rx_input_shifter_reg.sv
module tb_serial_rx_input_shifter_reg;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       shift;
  logic       data;
  logic       receive;
  logic       sm0;
  logic       load;
  logic [7:0] sbuf;
  logic       end_bit;
  logic       rb8;

  int errors = 0;
  int checks = 0;

  serial_rx_input_shifter_reg dut (
    .serial_clock_i                 (clk),
    .serial_reset_i_b               (rst_n),
    .serial_start_input_shift_reg_i (start),
    .serial_shift_input_shift_reg_i (shift),
    .serial_data_i                  (data),
    .serial_receive_i               (receive),
    .serial_scon7_sm0_i             (sm0),
    .serial_load_sbuf_i             (load),
    .serial_sbuf_rx_o               (sbuf),
    .serial_end_bit_o               (end_bit),
    .serial_scon2_rb8_o             (rb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which data bits were received after the start bit. The frame
  // value is rebuilt from that list: the k received bits sit at the top of
  // a 9-bit window, with 1s filling the unused low positions.
  int m_cnt;
  int m_k;
  int m_bits[9];
  bit m_end;
  bit m_abort;
  int m_sbuf;
  int m_rb8;

  function automatic int frame_word();
    int r;
    r = (1 << (9 - m_k)) - 1;
    for (int j = 0; j < m_k; j++) r = r | (m_bits[j] << (9 - m_k + j));
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    int n;
    if (!rst_n) begin
      m_cnt = 0; m_k = 0; m_end = 0; m_abort = 0; m_sbuf = 0; m_rb8 = 0;
      for (int j = 0; j < 9; j++) m_bits[j] = 0;
    end else begin
      n = sm0 ? 10 : 9;
      w = frame_word();
      if (load) begin
        if (sm0) begin
          m_sbuf = w % 256;
          m_rb8  = w / 256;
        end else begin
          m_sbuf = w / 2;
          m_rb8  = int'(data);
        end
      end
      if (start) begin
        m_cnt = 0; m_k = 0; m_end = 0; m_abort = 0;
      end else if (shift && receive && !m_abort && m_cnt < n) begin
        if (m_cnt == 0) begin
`ifdef SERIAL_RX_START_CHECK_EN
          if (data) m_abort = 1;
          else m_cnt = 1;
`else
          m_cnt = 1;
`endif
        end else begin
          m_bits[m_k] = int'(data);
          m_k++;
          m_cnt++;
        end
        if (m_cnt == n) m_end = 1;
      end
    end
  end

  // Compare on every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("model_sbuf", int'(sbuf), m_sbuf);
    check("model_rb8", int'(rb8), m_rb8);
    check("model_end", int'(end_bit), int'(m_end));
  end

  // ---------------- stimulus helpers ----------------
  // Every helper starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_shift(input logic d);
    shift = 1'b1;
    data  = d;
    step();
    shift = 1'b0;
  endtask

  task automatic do_load(input logic d);
    load = 1'b1;
    data = d;
    step();
    load = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 8; i++) do_shift(v[i]);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; shift = 1'b1; data = 1'b1;
    receive = 1'b1; sm0 = 1'b0; load = 1'b1;

    // Reset with load and shift active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_sbuf", int'(sbuf), 0);
      check("rst_rb8", int'(rb8), 0);
      check("rst_end", int'(end_bit), 0);
    end
    step();
    shift = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    step();
    $display("reset done: sbuf=%h rb8=%b end=%b", sbuf, rb8, end_bit);

    // SM0=0, 9 shifts of 1.
    sm0 = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) do_shift(1'b1);
    check("t1_end_before", int'(end_bit), 0);
    do_shift(1'b1);
`ifndef SERIAL_RX_START_CHECK_EN
    check("t1_end_after", int'(end_bit), 1);
`endif
    do_load(1'b1);
    check("t1_sbuf", int'(sbuf), 8'hFF);
    check("t1_rb8", int'(rb8), 1);
    $display("frame SM0=0 all-ones: sbuf=%h rb8=%b end=%b", sbuf, rb8, end_bit);

    // SM0=0, data F5.
    do_start();
    check("t2_end_cleared", int'(end_bit), 0);
    do_shift(1'b0);
    shift_byte(8'hF5);
    check("t2_end", int'(end_bit), 1);
    do_load(1'b1);
    check("t2_sbuf", int'(sbuf), 8'hF5);
    check("t2_rb8", int'(rb8), 1);
    $display("frame SM0=0 F5: sbuf=%h rb8=%b end=%b", sbuf, rb8, end_bit);

    // SM0=1, data 3C, ninth bit 0, then an extra shift.
    sm0 = 1'b1;
    do_start();
    do_shift(1'b0);
    shift_byte(8'h3C);
    check("t3_end_before", int'(end_bit), 0);
    do_shift(1'b0);
    check("t3_end_after", int'(end_bit), 1);
    do_load(1'b1);
    check("t3_sbuf", int'(sbuf), 8'h3C);
    check("t3_rb8", int'(rb8), 0);
    do_shift(1'b1);
    do_load(1'b1);
    check("t3_sbuf_extra", int'(sbuf), 8'h3C);
    check("t3_rb8_extra", int'(rb8), 0);
    $display("frame SM0=1 3C: sbuf=%h rb8=%b end=%b", sbuf, rb8, end_bit);

    // A load in the same cycle as start captures the old frame.
    start = 1'b1;
    do_load(1'b0);
    start = 1'b0;
    check("t4_load_start_sbuf", int'(sbuf), 8'h3C);
    check("t4_load_start_end", int'(end_bit), 0);
    $display("load+start: sbuf=%h end=%b", sbuf, end_bit);

    // Shifts with receive=0 are ignored.
    sm0 = 1'b0;
    receive = 1'b0;
    for (int i = 0; i < 12; i++) do_shift(1'b0);
    receive = 1'b1;
    check("t5_rx_off_end", int'(end_bit), 0);
    do_load(1'b0);
    check("t5_rx_off_sbuf", int'(sbuf), 8'hFF);
    check("t5_rx_off_rb8", int'(rb8), 0);
    $display("receive off: sbuf=%h rb8=%b", sbuf, rb8);

    // Partial frame load, then load and shift in the same cycle.
    do_shift(1'b0);
    do_shift(1'b0);
    do_shift(1'b0);
    do_load(1'b1);
    check("t6_partial_sbuf", int'(sbuf), 8'h3F);
    shift = 1'b1;
    load  = 1'b1;
    data  = 1'b0;
    step();
    shift = 1'b0; load = 1'b0;
    check("t6_load_shift_sbuf", int'(sbuf), 8'h3F);
    do_load(1'b0);
    check("t6_after_shift_sbuf", int'(sbuf), 8'h1F);
    $display("partial loads: sbuf=%h rb8=%b", sbuf, rb8);

`ifdef SERIAL_RX_START_CHECK_EN
    // False start bit.
    do_start();
    do_shift(1'b1);
    for (int i = 0; i < 8; i++) do_shift(1'b0);
    check("t7_false_start_end", int'(end_bit), 0);
    do_load(1'b1);
    check("t7_false_start_sbuf", int'(sbuf), 8'hFF);
    $display("false start: sbuf=%h end=%b", sbuf, end_bit);
`endif

    // Reset in mid-frame aborts the reception.
    do_start();
    do_shift(1'b0);
    do_shift(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_rst_sbuf", int'(sbuf), 0);
    step();
    rst_n = 1'b1;
    step();
    $display("mid-frame reset: sbuf=%h end=%b", sbuf, end_bit);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
